usbfs_endp_tx_dbuf: RTL

Double-buffered, parametrised USB full-speed IN-endpoint transmit buffer; the next generation of the single-packet endpoint TX block. It sits between a byte-stream producer and the USB transaction layer. It packs bytes into two ping-pong packet buffers so the producer keeps filling one buffer while the other is offered to the host. It also adds end-of-transfer marking, zero-length-packet (ZLP) generation, an idle-flush timeout, software halt (STALL) and flush.

---
 rtl/usbfs_pkg.sv | 18 +
 rtl/usbfs_endp_tx_buf.sv | 49 ++++
 rtl/usbfs_endp_tx_dbuf.sv | 151 +++++++++++++++
 3 files changed

// File: rtl/usbfs_pkg.sv
// Shared USB full-speed definitions used by the endpoint blocks.
package usbfs_pkg;

  // Width of one USB data byte.
  localparam int BYTE_W = 8;

  // Width of a packet length field able to hold 0..max_pkt.
  function automatic int nbytes_w(input int max_pkt);
    return $clog2(max_pkt) + 1;
  endfunction

  // Endpoint halt state, shared with the control endpoint (SET/CLEAR_FEATURE).
  typedef enum logic {
    EP_ACTIVE = 1'b0,
    EP_HALTED = 1'b1
  } ep_halt_e;

endpackage

// File: rtl/usbfs_endp_tx_buf.sv
// One packet buffer: byte write port, fill count and committed flag.
// Writes land at index count; bytes past count keep their old contents.
module usbfs_endp_tx_buf
  import usbfs_pkg::*;
#(
  parameter int MAX_PKT = 8,
  localparam int NBW = nbytes_w(MAX_PKT)
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      wr_en,
  input  logic [BYTE_W-1:0]         wr_data,
  input  logic                      commit,
  input  logic                      clear,
  output logic [BYTE_W*MAX_PKT-1:0] data,
  output logic [NBW-1:0]            n_bytes,
  output logic                      committed
);

  logic [NBW-1:0] count;

  assign n_bytes = count;

  // Fill count and committed flag; clear (drain or flush) wins over write/commit.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count     <= '0;
      committed <= 1'b0;
    end else if (clear) begin
      count     <= '0;
      committed <= 1'b0;
    end else begin
      if (wr_en) count <= count + NBW'(1);
      if (commit) committed <= 1'b1;
    end
  end

  // Byte storage; only the slot at the current count is written.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      data <= '0;
    end else if (wr_en && !clear) begin
      for (int i = 0; i < MAX_PKT; i++) begin
        if (count == NBW'(i)) data[i*BYTE_W +: BYTE_W] <= wr_data;
      end
    end
  end

endmodule

// File: rtl/usbfs_endp_tx_dbuf.sv
// Double-buffered USB full-speed IN-endpoint transmit buffer.
// Handshakes: a transfer happens on a rising clock edge where both valid and
// ready are high (o_ready/i_valid upstream, o_etValid/i_etReady downstream);
// valid never depends on ready, and a byte or packet is held until taken.
// The producer fills buffer[fill_sel] while buffer[drain_sel] is offered.
module usbfs_endp_tx_dbuf
  import usbfs_pkg::*;
#(
  parameter int MAX_PKT = 8,
  parameter bit ZLP_EN  = 1'b1,
  parameter int TIMEOUT = 255,
  localparam int NBW = nbytes_w(MAX_PKT)
) (
  input  logic                      i_clk,
  input  logic                      i_rst,
  output logic                      o_ready,
  input  logic                      i_valid,
  input  logic [BYTE_W-1:0]         i_data,
  input  logic                      i_last,
  input  logic                      i_haltSet,
  input  logic                      i_haltClr,
  input  logic                      i_flush,
  output logic                      o_etStall,
  input  logic                      i_etReady,
  output logic                      o_etValid,
  output logic [BYTE_W*MAX_PKT-1:0] o_etData,
  output logic [NBW-1:0]            o_etData_nBytes
);

  localparam int IDW = (TIMEOUT > 1) ? $clog2(TIMEOUT + 1) : 1;

  logic [1:0]               n_committed;
  logic                     fill_sel;
  logic                     drain_sel;
  logic                     zlp_pending;
  logic [IDW-1:0]           idle_cnt;
  ep_halt_e                 halt;

  logic [BYTE_W*MAX_PKT-1:0] buf_data [2];
  logic [NBW-1:0]            buf_cnt [2];
  logic [1:0]                buf_committed;
  logic [1:0]                buf_wr;
  logic [1:0]                buf_commit;
  logic [1:0]                buf_clear;

  logic           accepted;
  logic [NBW-1:0] fill_cnt;
  logic           fill_last_slot;
  logic           idle_expire;
  logic           data_commit;
  logic           zlp_set;
  logic           zlp_commit;
  logic           commit;
  logic           et_valid;
  logic           et_accepted;

  // A committed fill buffer (both buffers full) holds no partial packet.
  assign fill_cnt       = buf_committed[fill_sel] ? '0 : buf_cnt[fill_sel];
  assign fill_last_slot = (fill_cnt == NBW'(MAX_PKT - 1));

  assign o_ready  = (n_committed != 2'd2) && !zlp_pending && !i_flush;
  assign accepted = o_ready && i_valid;

  assign idle_expire = (TIMEOUT != 0) && !accepted && !i_flush &&
                       (fill_cnt != '0) && (idle_cnt == IDW'(TIMEOUT - 1));
  assign data_commit = (accepted && (fill_last_slot || i_last)) || idle_expire;
  assign zlp_set     = ZLP_EN && accepted && i_last && fill_last_slot;
  // The ZLP commits the (empty) fill buffer once a buffer slot is free.
  assign zlp_commit  = zlp_pending && (n_committed != 2'd2) && !i_flush;
  assign commit      = data_commit || zlp_commit;

  assign et_valid    = buf_committed[drain_sel] && (halt == EP_ACTIVE);
  assign et_accepted = et_valid && i_etReady;

  // Outputs come straight from state flops through the drain mux.
  assign o_etValid       = et_valid;
  assign o_etStall       = (halt == EP_HALTED);
  assign o_etData        = buf_data[drain_sel];
  assign o_etData_nBytes = buf_cnt[drain_sel];

  // Per-buffer strobes steered by the fill and drain selects.
  always_comb begin
    buf_wr     = '0;
    buf_commit = '0;
    buf_clear  = '0;
    for (int b = 0; b < 2; b++) begin
      buf_wr[b]     = accepted && (fill_sel == 1'(b));
      buf_commit[b] = commit && (fill_sel == 1'(b));
      buf_clear[b]  = i_flush || (et_accepted && (drain_sel == 1'(b)));
    end
  end

  for (genvar g = 0; g < 2; g++) begin : g_buf
    usbfs_endp_tx_buf #(.MAX_PKT(MAX_PKT)) u_buf (
      .clk       (i_clk),
      .rst       (i_rst),
      .wr_en     (buf_wr[g]),
      .wr_data   (i_data),
      .commit    (buf_commit[g]),
      .clear     (buf_clear[g]),
      .data      (buf_data[g]),
      .n_bytes   (buf_cnt[g]),
      .committed (buf_committed[g])
    );
  end

  // Ping-pong selects, committed-packet count and pending ZLP.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      n_committed <= '0;
      fill_sel    <= 1'b0;
      drain_sel   <= 1'b0;
      zlp_pending <= 1'b0;
    end else if (i_flush) begin
      n_committed <= '0;
      fill_sel    <= 1'b0;
      drain_sel   <= 1'b0;
      zlp_pending <= 1'b0;
    end else begin
      if (commit) fill_sel <= ~fill_sel;
      if (et_accepted) drain_sel <= ~drain_sel;
      if (commit && !et_accepted) n_committed <= n_committed + 2'd1;
      else if (!commit && et_accepted) n_committed <= n_committed - 2'd1;
      if (zlp_set) zlp_pending <= 1'b1;
      else if (zlp_commit) zlp_pending <= 1'b0;
    end
  end

  // Idle counter for flushing a partial packet; saturates at TIMEOUT.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      idle_cnt <= '0;
    end else if (i_flush || accepted || (fill_cnt == '0)) begin
      idle_cnt <= '0;
    end else if (idle_cnt != IDW'(TIMEOUT)) begin
      idle_cnt <= idle_cnt + IDW'(1);
    end
  end

  // Endpoint halt; set wins over clear, flush leaves it alone.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      halt <= EP_ACTIVE;
    end else if (i_haltSet) begin
      halt <= EP_HALTED;
    end else if (i_haltClr) begin
      halt <= EP_ACTIVE;
    end
  end

endmodule
